// File: rtl/autoconfig_pkg.sv
// autoconfig_pkg -- shared definitions for the Zorro II AutoConfig responder.
//   * cfg_state_t : responder state encoding
//   * REG_*       : AutoConfig register offsets (byte offsets in $E80000 space)
//   * ER_TYPE_*   : er_Type byte for the 4 MB and 8 MB board variants
package autoconfig_pkg;

  typedef enum logic [2:0] {
    ST_UNCONF     = 3'd0,
    ST_READ       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_WAIT_END   = 3'd3,
    ST_CONFIGURED = 3'd4,
    ST_SHUTUP     = 3'd5
  } cfg_state_t;

  localparam logic [7:0] REG_TYPE      = 8'h00;
  localparam logic [7:0] REG_PRODUCT   = 8'h04;
  localparam logic [7:0] REG_FLAGS     = 8'h08;
  localparam logic [7:0] REG_MANUF     = 8'h10;
  localparam logic [7:0] REG_MANUF_LO  = 8'h14;
  localparam logic [7:0] REG_SERIAL    = 8'h18;
  localparam logic [7:0] REG_SERIAL_LO = 8'h1C;
  localparam logic [7:0] REG_BASE      = 8'h48;
  localparam logic [7:0] REG_SHUTUP    = 8'h4C;

  // er_Type: Zorro II, link into memory list, size code 0 = 8 MB / 7 = 4 MB.
  localparam logic [7:0] ER_TYPE_8MB = 8'hE0;
  localparam logic [7:0] ER_TYPE_4MB = 8'hE7;

  // "Prefer 8 MB space" flag byte, stored inverted like all non-type bytes.
  localparam logic [7:0] ER_FLAGS    = 8'h80;

endpackage

// File: rtl/autoconfig_z2_sync2.sv
// sync2 -- two-flop synchroniser for one bus strobe, reset to the
// inactive (high) level.
//   clk : sampling clock
//   rst : asynchronous active-high reset, forces q to 1
//   d   : asynchronous input
//   q   : synchronised output
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of the asynchronous strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/autoconfig_z2.sv
// autoconfig_z2 -- Zorro II AutoConfig responder for the fast RAM board.
// Answers reads in $E80000 space with the identity nibbles, captures the
// base written by Kickstart and then enables the fast-RAM decoder.
// Optional feature macro: AUTOCONFIG_SERIAL_EN (serial number at $18-$1E).
//
// Ports:
//   CLK              in   system clock, rising edge
//   RESET            in   asynchronous active-high reset
//   A[23:1]          in   CPU address bus
//   AS_n, UDS_n      in   address / upper data strobes (async, synchronised here)
//   RW_n             in   1 = read
//   D_IN[15:12]      in   write data nibble
//   CFGIN_n          in   0 = this board may configure
//   JP2              in   1 = 8 MB board, 0 = 4 MB board
//   D_OUT[15:12]     out  read data nibble (4'hF when not driving)
//   D_OE             out  D[15:12] output buffer enable
//   BASE_RAM[7:5]    out  A[23:21] of the assigned base
//   RAM_CONFIGURED_n out  0 = base valid, decode enabled
//   CFGOUT_n         out  0 = pass the chain to the next board
module autoconfig_z2 #(
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [31:0] SERIAL_NO  = 32'h0000_0001
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        RW_n,
  input  logic [15:12] D_IN,
  input  logic        CFGIN_n,
  input  logic        JP2,
  output logic [15:12] D_OUT,
  output logic        D_OE,
  output logic [7:5]  BASE_RAM,
  output logic        RAM_CONFIGURED_n,
  output logic        CFGOUT_n
);

  import autoconfig_pkg::*;

  logic       as_s;
  logic       ds_s;
  logic       rw_s;
  cfg_state_t state_r;
  logic       pend_cfg_r;
  logic       pend_shut_r;
  logic [7:0] reg_off_s;
  logic       cfg_hit_s;

  sync2 u_sync_as (.clk(CLK), .rst(RESET), .d(AS_n),  .q(as_s));
  sync2 u_sync_ds (.clk(CLK), .rst(RESET), .d(UDS_n), .q(ds_s));
  sync2 u_sync_rw (.clk(CLK), .rst(RESET), .d(RW_n),  .q(rw_s));

  // Byte offset inside the configuration space; A[0] does not exist.
  assign reg_off_s = {A[7:1], 1'b0};

  assign cfg_hit_s = !as_s && (A[23:16] == 8'hE8) && !CFGIN_n &&
                     (state_r == ST_UNCONF);

  // Bits that take no part in decoding.
  logic unused_s;
  assign unused_s = &{1'b0, A[15:8], D_IN[12]};

  // Each register byte spans four offsets: high nibble at R, low at R+2.
  // Every byte except er_Type is presented inverted.
  function automatic logic [3:0] id_nibble(input logic [7:0] off, input logic jp2);
    logic [7:0] raw;
    case (off & 8'hFC)
      REG_TYPE:      raw = jp2 ? ER_TYPE_8MB : ER_TYPE_4MB;
      REG_PRODUCT:   raw = ~PRODUCT_ID;
      REG_FLAGS:     raw = ~ER_FLAGS;
      REG_MANUF:     raw = ~MANUF_ID[15:8];
      REG_MANUF_LO:  raw = ~MANUF_ID[7:0];
`ifdef AUTOCONFIG_SERIAL_EN
      // Four nibble slots carry the low 16 serial bits, MS byte first.
      REG_SERIAL:    raw = ~SERIAL_NO[15:8];
      REG_SERIAL_LO: raw = ~SERIAL_NO[7:0];
`endif
      default:       raw = 8'hFF;
    endcase
    return off[1] ? raw[3:0] : raw[7:4];
  endfunction

`ifndef AUTOCONFIG_SERIAL_EN
  logic [31:0] unused_serial_s;
  assign unused_serial_s = SERIAL_NO;
`endif

  // Responder state machine with registered bus and decoder outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r          <= ST_UNCONF;
      D_OUT            <= 4'hF;
      D_OE             <= 1'b0;
      BASE_RAM         <= 3'b000;
      RAM_CONFIGURED_n <= 1'b1;
      CFGOUT_n         <= 1'b1;
      pend_cfg_r       <= 1'b0;
      pend_shut_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_UNCONF: begin
          if (cfg_hit_s && rw_s) begin
            state_r <= ST_READ;
            D_OE    <= 1'b1;
            D_OUT   <= id_nibble(reg_off_s, JP2);
          end else if (cfg_hit_s && !ds_s) begin
            state_r <= ST_WRITE;
            D_OE    <= 1'b0;
            D_OUT   <= 4'hF;
          end else begin
            state_r <= ST_UNCONF;
            D_OE    <= 1'b0;
            D_OUT   <= 4'hF;
          end
        end
        ST_READ: begin
          if (as_s) begin
            state_r <= ST_UNCONF;
            D_OE    <= 1'b0;
            D_OUT   <= 4'hF;
          end else begin
            D_OUT   <= id_nibble(reg_off_s, JP2);
          end
        end
        ST_WRITE: begin
          // D_IN is stable by the time the synchronised strobes arrive.
          if (reg_off_s == REG_BASE) begin
            BASE_RAM   <= D_IN[15:13];
            pend_cfg_r <= 1'b1;
          end else if (reg_off_s == REG_SHUTUP) begin
            pend_shut_r <= 1'b1;
          end else begin
            pend_cfg_r <= pend_cfg_r;
          end
          state_r <= ST_WAIT_END;
        end
        ST_WAIT_END: begin
          // Decoder is only enabled once the bus cycle has fully ended.
          if (as_s) begin
            if (pend_cfg_r) begin
              state_r          <= ST_CONFIGURED;
              RAM_CONFIGURED_n <= 1'b0;
              CFGOUT_n         <= 1'b0;
            end else if (pend_shut_r) begin
              state_r  <= ST_SHUTUP;
              CFGOUT_n <= 1'b0;
            end else begin
              state_r <= ST_UNCONF;
            end
          end else begin
            state_r <= ST_WAIT_END;
          end
        end
        ST_CONFIGURED: begin
          state_r <= ST_CONFIGURED;
        end
        ST_SHUTUP: begin
          state_r <= ST_SHUTUP;
        end
        default: begin
          state_r <= ST_UNCONF;
          D_OE    <= 1'b0;
          D_OUT   <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_autoconfig_z2.sv
// tb_autoconfig_z2 -- self-checking bench for autoconfig_z2. Directed
// scenarios plus a randomized bus-cycle sequence checked against a
// register-image / chain-slot reference model.
module tb_autoconfig_z2;

  localparam logic [15:0] M_MANUF   = 16'h07DB;
  localparam logic [7:0]  M_PRODUCT = 8'h01;
  localparam logic [31:0] M_SERIAL  = 32'h0000_0001;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [23:1] A = '0;
  logic        AS_n = 1'b1;
  logic        UDS_n = 1'b1;
  logic        RW_n = 1'b1;
  logic [15:12] D_IN = 4'h0;
  logic        CFGIN_n = 1'b0;
  logic        JP2 = 1'b1;
  logic [15:12] D_OUT;
  logic        D_OE;
  logic [7:5]  BASE_RAM;
  logic        RAM_CONFIGURED_n;
  logic        CFGOUT_n;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the chain slot.
  bit         m_conf = 1'b0;
  bit         m_shut = 1'b0;
  logic [2:0] m_base = 3'b000;

  autoconfig_z2 dut (
    .CLK(CLK), .RESET(RESET), .A(A), .AS_n(AS_n), .UDS_n(UDS_n), .RW_n(RW_n),
    .D_IN(D_IN), .CFGIN_n(CFGIN_n), .JP2(JP2), .D_OUT(D_OUT), .D_OE(D_OE),
    .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .CFGOUT_n(CFGOUT_n)
  );

  always #70 CLK = ~CLK;

  // Expected nibble at byte offset off, built from the register image.
  function automatic logic [3:0] model_nib(input logic [7:0] off, input logic jp2);
    logic [7:0]  b;
    logic [15:0] inv_man;
    logic [31:0] inv_ser;
    inv_man = ~M_MANUF;
    inv_ser = ~M_SERIAL;
    case (off[7:2])
      6'h00: b = jp2 ? 8'hE0 : 8'hE7;
      6'h01: b = ~M_PRODUCT;
      6'h02: b = 8'h7F;
      6'h04: b = inv_man[15:8];
      6'h05: b = inv_man[7:0];
`ifdef AUTOCONFIG_SERIAL_EN
      6'h06: b = inv_ser[15:8];
      6'h07: b = inv_ser[7:0];
`endif
      default: b = 8'hFF;
    endcase
    return off[1] ? b[3:0] : b[7:4];
  endfunction

  function automatic bit model_active();
    return !m_conf && !m_shut && !CFGIN_n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_addr(input logic [7:0] off);
    logic [7:0] mid;
    mid = 8'($urandom_range(0, 255));
    A = {8'hE8, mid, off[7:1]};
  endtask

  task automatic apply_reset();
    tick();
    RESET = 1'b1;
    AS_n = 1'b1; UDS_n = 1'b1; RW_n = 1'b1;
    #1;
    tests_run++;
    if (D_OE !== 1'b0 || D_OUT !== 4'hF || BASE_RAM !== 3'b000 ||
        RAM_CONFIGURED_n !== 1'b1 || CFGOUT_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_vals: oe=%b dout=%h base=%b cfg_n=%b cfgout_n=%b, want 0 f 000 1 1",
               D_OE, D_OUT, BASE_RAM, RAM_CONFIGURED_n, CFGOUT_n);
    end
    tick(); tick();
    RESET = 1'b0;
    m_conf = 1'b0; m_shut = 1'b0; m_base = 3'b000;
    tick();
  endtask

  task automatic bus_read(input logic [7:0] off);
    bit         resp;
    logic [3:0] exp_nib;
    int         k;
    bit         seen;
    resp    = model_active();
    exp_nib = model_nib(off, JP2);
    set_addr(off);
    AS_n = 1'b0; UDS_n = 1'b0; RW_n = 1'b1;
    if (resp) begin
      k = 0;
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (D_OE === 1'b1) begin k = i; break; end
      end
      tests_run++;
      if (k != 3) begin
        tests_failed++;
        $display("FAIL rd_rise off=%h: D_OE rose after %0d edges, want 3", off, k);
      end
      tests_run++;
      if (D_OUT !== exp_nib) begin
        tests_failed++;
        $display("FAIL rd_data off=%h jp2=%b: got %h want %h", off, JP2, D_OUT, exp_nib);
      end
      AS_n = 1'b1; UDS_n = 1'b1;
      k = 0;
      for (int i = 1; i <= 8; i++) begin
        tick();
        if (D_OE === 1'b0) begin k = i; break; end
      end
      tests_run++;
      if (k != 3 || D_OUT !== 4'hF) begin
        tests_failed++;
        $display("FAIL rd_fall off=%h: D_OE fell after %0d edges dout=%h, want 3 and f", off, k, D_OUT);
      end
    end else begin
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (D_OE !== 1'b0 || D_OUT !== 4'hF) seen = 1'b1;
      end
      tests_run++;
      if (seen) begin
        tests_failed++;
        $display("FAIL rd_silent off=%h: board responded, want no response", off);
      end
      AS_n = 1'b1; UDS_n = 1'b1;
      for (int i = 0; i < 4; i++) tick();
    end
    tick();
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [3:0] d);
    bit old_conf;
    old_conf = m_conf;
    if (model_active()) begin
      if (off == 8'h48) begin
        m_conf = 1'b1; m_base = d[3:1];
      end else if (off == 8'h4C) begin
        m_shut = 1'b1;
      end
    end
    set_addr(off);
    D_IN = d;
    AS_n = 1'b0; UDS_n = 1'b0; RW_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (RAM_CONFIGURED_n !== !old_conf || BASE_RAM !== m_base || D_OE !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_during off=%h: cfg_n=%b base=%b oe=%b, want %b %b 0",
               off, RAM_CONFIGURED_n, BASE_RAM, D_OE, !old_conf, m_base);
    end
    AS_n = 1'b1; UDS_n = 1'b1; RW_n = 1'b1;
    tick(); tick();
    tests_run++;
    if (RAM_CONFIGURED_n !== !old_conf) begin
      tests_failed++;
      $display("FAIL wr_early off=%h: cfg_n=%b before cycle end, want %b", off, RAM_CONFIGURED_n, !old_conf);
    end
    tick();
    tests_run++;
    if (RAM_CONFIGURED_n !== !m_conf || CFGOUT_n !== !(m_conf || m_shut) || BASE_RAM !== m_base) begin
      tests_failed++;
      $display("FAIL wr_after off=%h: cfg_n=%b cfgout_n=%b base=%b, want %b %b %b",
               off, RAM_CONFIGURED_n, CFGOUT_n, BASE_RAM, !m_conf, !(m_conf || m_shut), m_base);
    end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_type_read();
    JP2 = 1'b1;
    bus_read(8'h00); bus_read(8'h02);
    JP2 = 1'b0;
    bus_read(8'h00); bus_read(8'h02);
    JP2 = 1'b1;
    bus_read(8'h04); bus_read(8'h06); bus_read(8'h08); bus_read(8'h0A);
  endtask

  task automatic test_manuf();
    bus_read(8'h10); bus_read(8'h12); bus_read(8'h14); bus_read(8'h16);
    bus_read(8'h40);
    bus_read(8'h1E); bus_read(8'h18);
  endtask

  task automatic test_cfgin();
    int k;
    CFGIN_n = 1'b1;
    bus_read(8'h00);
    bus_write(8'h48, 4'h6);
    CFGIN_n = 1'b0;
    // Chain enable drops mid-read: cycle completes.
    set_addr(8'h00);
    AS_n = 1'b0; UDS_n = 1'b0; RW_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    CFGIN_n = 1'b1;
    tick(); tick();
    tests_run++;
    if (D_OE !== 1'b1 || D_OUT !== model_nib(8'h00, JP2)) begin
      tests_failed++;
      $display("FAIL cfgin_midcycle: oe=%b dout=%h, want 1 %h", D_OE, D_OUT, model_nib(8'h00, JP2));
    end
    AS_n = 1'b1; UDS_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (D_OE === 1'b0) begin k = i; break; end
    end
    tests_run++;
    if (k != 3) begin
      tests_failed++;
      $display("FAIL cfgin_end: D_OE fell after %0d edges, want 3", k);
    end
    tick();
    bus_read(8'h02);
    CFGIN_n = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    set_addr(8'h00);
    AS_n = 1'b0; UDS_n = 1'b0; RW_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #20;
    RESET = 1'b1;
    #1;
    tests_run++;
    if (D_OE !== 1'b0 || D_OUT !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_async: oe=%b dout=%h, want 0 f", D_OE, D_OUT);
    end
    AS_n = 1'b1; UDS_n = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tick();
    bus_read(8'h12);
  endtask

  task automatic test_configure();
    bus_write(8'h40, 4'h9);
    bus_read(8'h00);
    bus_write(8'h48, 4'h2);
    bus_read(8'h00);
    bus_write(8'h48, 4'hE);
    bus_write(8'h4C, 4'h0);
  endtask

  task automatic test_shutup();
    apply_reset();
    bus_write(8'h4C, 4'h0);
    bus_read(8'h00);
    bus_write(8'h48, 4'hA);
  endtask

  task automatic test_random();
    logic [7:0] off;
    for (int n = 0; n < 40; n++) begin
      if ((m_conf || m_shut) && $urandom_range(0, 2) == 0) apply_reset();
      JP2     = 1'($urandom_range(0, 1));
      CFGIN_n = ($urandom_range(0, 9) == 0);
      off     = {7'($urandom_range(0, 127)), 1'b0};
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: off = 8'h48;
          1: off = 8'h4C;
          default: off = {7'($urandom_range(0, 127)), 1'b0};
        endcase
        bus_write(off, 4'($urandom_range(0, 15)));
      end else begin
        if ($urandom_range(0, 1) == 0) off = {3'b000, 4'($urandom_range(0, 15)), 1'b0};
        bus_read(off);
      end
    end
    CFGIN_n = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_type_read();
    test_manuf();
    test_cfgin();
    test_reset_mid_read();
    test_configure();
    test_shutup();
    apply_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
